// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline memory stage: one outstanding
// load/store, programmable wait latency, byte/half/word store lanes.

// One byte lane of the data array. Storage is intentionally not reset.
module dmem_lane #(
    parameter int IDXW        = 10,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IDXW-1:0] idx,
    input  logic [7:0]      wbyte,
    output logic [7:0]      rbyte
);
    logic [7:0] mem [DEPTH_WORDS];

    // Byte write on the commit edge only.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wbyte;
    end

    assign rbyte = mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);
    localparam int          NUM_LANES = 4;
    localparam int          IDXW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH31   = 31'(DEPTH_WORDS);

    typedef struct packed {
        logic        write;
        logic [1:0]  store;
        logic [31:0] addr;
        logic [31:0] wdata;
    } reqT;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT      state, stateNxt;
    logic [3:0] cnt, cntNxt;
    logic       commit;
    reqT        held, cur;
    logic       misalign, reserved, outOfRange, accErr;

    logic [IDXW-1:0]                 curIdx;
    logic [NUM_LANES-1:0]            laneWe;
    logic [NUM_LANES-1:0][7:0]       laneWdata;
    logic [NUM_LANES-1:0][7:0]       laneRdata;

    // State and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
        end
    end

    // Next state; commit marks the edge that enters RESP.
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cntNxt = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        stateNxt = RESP;
                        commit   = 1'b1;
                    end else begin
                        stateNxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cntNxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    stateNxt = RESP;
                    commit   = 1'b1;
                end
            end
            RESP:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Latch the request at acceptance; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) held <= '0;
        else if (state == IDLE && req_valid)
            held <= {req_write, req_store, req_addr, req_wdata};
    end

    // Zero latency commits on the acceptance edge, so use live inputs in IDLE.
    always_comb begin
        if (state == IDLE) cur = {req_write, req_store, req_addr, req_wdata};
        else               cur = held;
        curIdx = cur.addr[IDXW+1:2];
    end

    // Alignment is judged by access size for loads and stores alike.
    always_comb begin
        case (cur.store)
            2'b01:   misalign = cur.addr[0];
            2'b10:   misalign = |cur.addr[1:0];
            default: misalign = 1'b0;
        endcase
        reserved   = cur.write && (cur.store == 2'b11);
        outOfRange = {1'b0, cur.addr[31:2]} >= DEPTH31;
        accErr     = misalign | reserved | outOfRange;
    end

    // Per-lane write enable and right-justified store data steering.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            laneWe[l]    = 1'b0;
            laneWdata[l] = cur.wdata[7:0];
            case (cur.store)
                2'b00: laneWe[l] = (cur.addr[1:0] == 2'(l));
                2'b01: begin
                    laneWe[l]    = (cur.addr[1] == l[1]);
                    laneWdata[l] = cur.wdata[8*(l%2) +: 8];
                end
                2'b10: begin
                    laneWe[l]    = 1'b1;
                    laneWdata[l] = cur.wdata[8*l +: 8];
                end
                default: laneWe[l] = 1'b0;
            endcase
            laneWe[l] = laneWe[l] & commit & cur.write & ~accErr & ~reset;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dmem_lane #(.IDXW(IDXW), .DEPTH_WORDS(DEPTH_WORDS)) uLane (
            .clk   (clk),
            .we    (laneWe[l]),
            .idx   (curIdx),
            .wbyte (laneWdata[l]),
            .rbyte (laneRdata[l])
        );
    end

    // Response data/error registered on the commit edge and held afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_err   <= accErr;
            resp_rdata <= (accErr || cur.write) ? 32'h0 : laneRdata;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (LATENCY 2 and 0) checked
// every cycle against a timestamp/array model, plus literal directed checks.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LATA  = 2;
    localparam int LATB  = 0;

    typedef struct {
        logic        w;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] wd;
    } mreqT;

    logic        clk = 0;
    logic        rst = 1;
    logic        vld [2];
    logic        wr  [2];
    logic [1:0]  st  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic        rdy [2];
    logic        rv  [2];
    logic [31:0] rd  [2];
    logic        er  [2];
    logic        stl [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic [31:0] mm [int];
    int          accA   [2];
    mreqT        pend   [2];
    logic [31:0] lastRd [2];
    logic        lastEr [2];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATA)) dutA (
        .clk(clk), .reset(rst), .req_valid(vld[0]), .req_write(wr[0]),
        .req_store(st[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
        .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]),
        .resp_err(er[0]), .stall(stl[0]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATB)) dutB (
        .clk(clk), .reset(rst), .req_valid(vld[1]), .req_write(wr[1]),
        .req_store(st[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
        .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]),
        .resp_err(er[1]), .stall(stl[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int u);
        return (u == 0) ? LATA : LATB;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endfunction

    // Spec-level effect of one access on the model array.
    function automatic void mdlCommit(input int u, input mreqT r, output logic [31:0] rdv, output logic e);
        longint      idx;
        int          sh;
        int          key;
        logic [31:0] msk, old;
        idx = longint'(r.a >> 2);
        e = (idx >= DEPTH) || (r.w && r.st == 2'd3) ||
            (r.st == 2'd1 && (r.a % 2) != 0) || (r.st == 2'd2 && (r.a % 4) != 0);
        rdv = 32'h0;
        if (e) return;
        key = u * 100000 + int'(idx);
        old = mm[key];
        if (!r.w) begin
            rdv = old;
            return;
        end
        case (r.st)
            2'd0:    begin msk = 32'hFF;   sh = 8 * int'(r.a % 4); end
            2'd1:    begin msk = 32'hFFFF; sh = 16 * int'((r.a % 4) / 2); end
            default: begin msk = 32'hFFFF_FFFF; sh = 0; end
        endcase
        mm[key] = (old & ~(msk << sh)) | ((r.wd & msk) << sh);
    endfunction

    // Per-cycle comparison: a request accepted at the end of cycle A keeps the
    // responder busy in A+1..A+L+1 and responds in A+L+1.
    always @(negedge clk) begin : cmpP
        logic [31:0] nrd;
        logic        ne, inWin, isResp, eRdy, eStall;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                accA[u]   = -100;
                lastRd[u] = 32'h0;
                lastEr[u] = 1'b0;
                chk("rst_ready", rdy[u], 1);
                chk("rst_valid", rv[u], 0);
                chk("rst_stall", stl[u], vld[u]);
                chk("rst_rdata", rd[u], 0);
                chk("rst_err",   er[u], 0);
            end else begin
                inWin  = (cyc >= accA[u] + 1) && (cyc <= accA[u] + latOf(u) + 1);
                isResp = (cyc == accA[u] + latOf(u) + 1);
                if (isResp) begin
                    mdlCommit(u, pend[u], nrd, ne);
                    lastRd[u] = nrd;
                    lastEr[u] = ne;
                end
                eRdy   = !inWin;
                eStall = (eRdy && vld[u]) || (inWin && !isResp);
                chk("ready", rdy[u], eRdy);
                chk("resp_valid", rv[u], isResp);
                chk("stall", stl[u], eStall);
                chk("resp_rdata", rd[u], lastRd[u]);
                chk("resp_err", er[u], lastEr[u]);
                if (eRdy && vld[u]) begin
                    accA[u] = cyc;
                    pend[u] = '{w: wr[u], st: st[u], a: ad[u], wd: wd[u]};
                end
            end
        end
    end

    // Present a request and hold it until the response strobe (bounded wait).
    // req_valid is left high so a following call runs back-to-back.
    task automatic doReq(input int u, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdo, output logic eo,
                         output int issueC, output int respC);
        int n;
        @(posedge clk); #1;
        vld[u] = 1; wr[u] = w; st[u] = s; ad[u] = a; wd[u] = d;
        issueC = cyc;
        respC = -1; rdo = 32'h0; eo = 1'b0; n = 0;
        while (respC < 0 && n < 40) begin
            @(negedge clk); #1;
            if (rv[u]) begin
                respC = cyc;
                rdo   = rd[u];
                eo    = er[u];
            end
            n++;
        end
        chk("resp_seen", (respC >= 0), 1);
    endtask

    task automatic idle(input int u);
        @(posedge clk); #1;
        vld[u] = 0;
        ad[u]  = $urandom;
        wd[u]  = $urandom;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r;
        logic        e;
        int          ic, rc, rc1, ic1;
        logic [31:0] a;
        for (int u = 0; u < 2; u++) begin
            vld[u] = 0; wr[u] = 0; st[u] = 0; ad[u] = 0; wd[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // known contents for the words the bench touches
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 16; i++) doReq(u, 1, 2'd2, 32'(i * 4), $urandom, r, e, ic, rc);
            idle(u);
        end
        repeat (2) @(posedge clk);

        // LATENCY=2 directed
        doReq(0, 1, 2'd2, 32'h10, 32'hDEAD_BEEF, r, e, ic, rc);
        chk("lat2_cycles", rc - ic, 3);
        chk("lat2_store_err", e, 0);
        doReq(0, 0, 2'd2, 32'h10, 32'h0, r, e, ic, rc);
        chk("load_10", r, 32'hDEAD_BEEF);
        doReq(0, 1, 2'd0, 32'h13, 32'h5555_55AA, r, e, ic, rc);
        doReq(0, 1, 2'd1, 32'h10, 32'hBEEF_1234, r, e, ic, rc);
        doReq(0, 0, 2'd2, 32'h10, 32'h0, r, e, ic, rc);
        chk("merge_10", r, 32'hAAAD_1234);
        doReq(0, 1, 2'd2, 32'h20, 32'h5A5A_0F0F, r, e, ic, rc);
        doReq(0, 1, 2'd1, 32'h21, 32'h0000_7777, r, e, ic, rc);
        chk("mis_half_err", e, 1);
        chk("mis_half_rdata", r, 0);
        doReq(0, 0, 2'd2, 32'h22, 32'h0, r, e, ic, rc);
        chk("mis_word_err", e, 1);
        doReq(0, 0, 2'd2, 32'h20, 32'h0, r, e, ic, rc);
        chk("orig_20", r, 32'h5A5A_0F0F);
        chk("orig_20_err", e, 0);
        doReq(0, 0, 2'd2, 32'h1000, 32'h0, r, e, ic, rc);
        chk("oor_err", e, 1);
        doReq(0, 1, 2'd3, 32'h24, 32'h1, r, e, ic, rc);
        chk("reserved_err", e, 1);

        // back-to-back with req_valid held through RESP
        doReq(0, 0, 2'd2, 32'h10, 32'h0, r, e, ic1, rc1);
        doReq(0, 0, 2'd2, 32'h20, 32'h0, r, e, ic, rc);
        chk("b2b_spacing", rc - rc1, LATA + 2);
        chk("b2b_data", r, 32'h5A5A_0F0F);

        // reset during WAIT of a store
        doReq(0, 1, 2'd2, 32'h30, 32'h1111_1111, r, e, ic, rc);
        @(posedge clk); #1;
        vld[0] = 1; wr[0] = 1; st[0] = 2'd2; ad[0] = 32'h30; wd[0] = 32'h2222_2222;
        @(posedge clk); #1;
        vld[0] = 0;
        #1 rst = 1;
        #1;
        chk("async_ready", rdy[0], 1);
        chk("async_valid", rv[0], 0);
        chk("async_stall", stl[0], 0);
        chk("async_rdata", rd[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        doReq(0, 0, 2'd2, 32'h30, 32'h0, r, e, ic, rc);
        chk("after_rst_30", r, 32'h1111_1111);
        idle(0);

        // LATENCY=0 directed
        doReq(1, 1, 2'd2, 32'h30, 32'hCAFE_F00D, r, e, ic, rc);
        chk("lat0_cycles", rc - ic, 1);
        doReq(1, 0, 2'd2, 32'h30, 32'h0, r, e, ic, rc);
        chk("lat0_load", r, 32'hCAFE_F00D);
        idle(1);

        // randomized traffic on both instances
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(9) == 0)
                    a = ($urandom_range(1) == 0) ? (32'h1000 + 32'($urandom_range(31))) : 32'hFFFF_FFFC;
                else
                    a = 32'($urandom_range(63));
                doReq(u, 1'($urandom), 2'($urandom), a, $urandom, r, e, ic, rc);
                if ($urandom_range(2) == 0) begin
                    idle(u);
                    repeat ($urandom_range(2)) @(posedge clk);
                end
            end
            idle(u);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the memory stage of the 5-stage RISC-V pipeline, which is the initiator.
- Accepts one load/store request at a time over a valid/ready handshake and applies store byte lanes (byte/half/word).
- Returns the aligned read word after a programmable wait latency; load sign/zero extension stays in write-back.
- Drives a stall output so the hazard logic can freeze the pipeline while an access is outstanding.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr[31:2].
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present; held stable by the initiator until resp_valid
- req_write  input  1  1 = store, 0 = load
- req_store  input  2  store size: 00 byte, 01 half, 10 word, 11 reserved
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_ready  output  1  responder can accept a request this cycle
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  32  aligned word read (loads); 0 for stores and errors
- resp_err  output  1  error qualifier, valid with resp_valid
- stall  output  1  pipeline hold request

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values:
  - state IDLE, wait counter 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0.
  - Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid: latch write, store, addr and wdata; load counter with LATENCY.
  - Go to WAIT if LATENCY>0, otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle; leave for RESP on the edge where the counter is 1.
  - WAIT lasts exactly LATENCY cycles.
- RESP:
  - Exactly one cycle with resp_valid=1; then return to IDLE.
  - req_ready=0 in RESP, so a request cannot be accepted in the same cycle as a response.
- Latency: request accepted at the end of cycle N gives resp_valid in cycle N+LATENCY+1.
- Throughput: at most one access per LATENCY+2 cycles.
- stall = (IDLE and req_valid) or WAIT. It is 0 in RESP, so the pipeline advances on the RESP edge.
- Commit edge: the edge entering RESP.
  - The store writes the array and resp_rdata/resp_err are registered on this edge.
  - For LATENCY=0 the commit edge is the acceptance edge.
- Store lanes:
  - byte: wdata[7:0] to lane addr[1:0].
  - half: wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - Other lanes are unchanged.
- Loads: resp_rdata = full word at addr[31:2]; addr[1:0] is ignored for data but checked for alignment.
- Errors set resp_err=1, write nothing, and set resp_rdata=0. Error conditions:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - req_store=11 on a store;
  - word index ≥ DEPTH_WORDS.
- Loads check alignment by req_store as well.
- Read-after-write: a request after RESP observes all prior committed stores.
- Inputs changing during WAIT/RESP are ignored; the latched copies are used.
- Reset mid-operation: returns to IDLE immediately. A store not yet at its commit edge is discarded, and no resp_valid is produced.
- resp_rdata and resp_err hold their last values outside RESP. Only resp_valid qualifies them.

Test Plan:
- LATENCY=2: word store of 0xDEADBEEF to 0x10, req_valid in cycle 0 -> stall=1 in cycles 0-2, req_ready=0 in cycles 1-3, resp_valid=1 only in cycle 3 with resp_err=0. A following load from 0x10 returns 0xDEADBEEF.
- Byte store 0xAA to 0x13, then half store 0x1234 to 0x10, onto word 0xDEADBEEF -> load 0x10 returns 0xAAAD1234.
- Misaligned accesses:
  - half store to 0x21 -> resp_err=1, resp_rdata=0.
  - word load from 0x22 -> resp_err=1.
  - Either way, a subsequent word load from 0x20 shows the original contents.
- Out of range: load from address 4*DEPTH_WORDS (0x1000) -> resp_err=1.
- Back-to-back: req_valid held through RESP for a second request -> second request accepted only in the IDLE cycle after RESP, with resp_valid exactly LATENCY+2 cycles apart.
- Reset mid-operation: reset asserted during WAIT of a store to 0x30 -> all outputs take reset values asynchronously and no resp_valid appears. After release, a load from 0x30 returns the pre-store value. Repeat with LATENCY=0 to confirm resp_valid in the cycle after acceptance.
